// File: rtl/rand_stream_mst_mc.sv
// rtl/rand_stream_mst_mc.sv - multi-channel LFSR-randomized ready/valid stream master
//
// Ports:
//   clk_i     clock
//   rst_ni    asynchronous active-low reset
//   enable_i  per-channel start/continue request
//   mode_i    data mode at each data update: 0 = LFSR data, 1 = handshake counter
//   data_o    per-channel payload, channel c at [c*DataWidth +: DataWidth]
//   valid_o   per-channel valid
//   ready_i   per-channel ready
//   count_o   per-channel completed handshakes (saturating), channel c at [c*32 +: 32]
//   done_o    channel has completed NumTransactions handshakes
module rand_stream_mst_mc #(
    parameter int unsigned NumChannels     = 4,
    parameter int unsigned DataWidth       = 32,
    parameter int unsigned MinWaitCycles   = 0,
    parameter int unsigned MaxWaitCycles   = 7,
    parameter logic [31:0] Seed            = 32'hACE12345,
    parameter int unsigned NumTransactions = 0
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumChannels-1:0]           enable_i,
    input  logic                             mode_i,
    output logic [NumChannels*DataWidth-1:0] data_o,
    output logic [NumChannels-1:0]           valid_o,
    input  logic [NumChannels-1:0]           ready_i,
    output logic [NumChannels*32-1:0]        count_o,
    output logic [NumChannels-1:0]           done_o
);

    if (MaxWaitCycles < MinWaitCycles) begin : g_bad_wait
        $error("MaxWaitCycles must be >= MinWaitCycles");
    end
    if (DataWidth < 1 || DataWidth > 64) begin : g_bad_width
        $error("DataWidth must be within 1..64");
    end
    if (NumChannels < 1) begin : g_bad_chan
        $error("NumChannels must be >= 1");
    end

    localparam logic [31:0] LfsrMask = 32'h80200003;
    localparam logic [31:0] WMin     = 32'(MinWaitCycles);
    localparam logic [31:0] WRange   = 32'(MaxWaitCycles - MinWaitCycles + 1);
    localparam logic [31:0] NTx      = 32'(NumTransactions);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        VALID,
        DONE
    } state_e;

    // Galois right-shift step; the mask is folded in when the bit shifted out is 1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return {1'b0, x[31:1]} ^ (x[0] ? LfsrMask : 32'h0);
    endfunction

    for (genvar c = 0; c < NumChannels; c++) begin : g_ch
        // Per-channel seeds are spread with the golden-ratio constant so channels
        // never share a sequence; zero would lock the LFSR, so it is replaced.
        localparam logic [31:0] Mix      = Seed ^ (32'(c) * 32'h9E3779B9);
        localparam logic [31:0] WaitInit = (Mix == 32'h0) ? 32'h1 : Mix;
        localparam logic [31:0] DataInit = (Mix == 32'hFFFFFFFF) ? 32'h1 : ~Mix;

        state_e                 state_q, state_d;
        logic [31:0]            cnt_q, cnt_d;
        logic [31:0]            wl_q, wl_d;
        logic [31:0]            dl_q, dl_d;
        logic [31:0]            count_q, count_d;
        logic [DataWidth-1:0]   data_q, data_d;
        logic [DataWidth-1:0]   ctr_q, ctr_d;
        logic [DataWidth-1:0]   upd_ctr;
        logic                   draw;
        logic [31:0]            wl_adv, dl_adv, w_val;

        assign wl_adv = lfsr_step(wl_q);
        assign dl_adv = lfsr_step(dl_q);
        assign w_val  = WMin + (wl_adv % WRange);

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            wl_d    = wl_q;
            dl_d    = dl_q;
            count_d = count_q;
            data_d  = data_q;
            ctr_d   = ctr_q;
            upd_ctr = ctr_q;
            draw    = 1'b0;

            case (state_q)
                IDLE: begin
                    if (enable_i[c]) begin
                        draw = 1'b1;
                    end
                end
                WAIT: begin
                    if (!enable_i[c]) begin
                        state_d = IDLE;
                    end else if (cnt_q == 32'd1) begin
                        state_d = VALID;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                VALID: begin
                    // Valid and data are held until the handshake whatever
                    // enable_i or mode_i do in the meantime.
                    if (ready_i[c]) begin
                        count_d = (count_q == 32'hFFFFFFFF) ? count_q : count_q + 32'd1;
                        ctr_d   = ctr_q + DataWidth'(1);
                        if (NTx != 32'd0 && count_d == NTx) begin
                            state_d = DONE;
                        end else if (!enable_i[c]) begin
                            state_d = IDLE;
                        end else begin
                            draw    = 1'b1;
                            upd_ctr = ctr_q + DataWidth'(1);
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            // A draw always pairs a wait draw with a data update.
            if (draw) begin
                wl_d = wl_adv;
                if (mode_i) begin
                    data_d = upd_ctr;
                end else begin
                    dl_d = dl_adv;
                    // {lfsr, lfsr} truncated to DataWidth
                    for (int b = 0; b < DataWidth; b++) begin
                        data_d[b] = dl_adv[b % 32];
                    end
                end
                if (w_val == 32'd0) begin
                    state_d = VALID;
                end else begin
                    state_d = WAIT;
                    cnt_d   = w_val;
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q <= IDLE;
                cnt_q   <= 32'd0;
                wl_q    <= WaitInit;
                dl_q    <= DataInit;
                count_q <= 32'd0;
                data_q  <= '0;
                ctr_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                wl_q    <= wl_d;
                dl_q    <= dl_d;
                count_q <= count_d;
                data_q  <= data_d;
                ctr_q   <= ctr_d;
            end
        end

        assign valid_o[c]                         = (state_q == VALID);
        assign done_o[c]                          = (state_q == DONE);
        assign data_o[c*DataWidth +: DataWidth]   = data_q;
        assign count_o[c*32 +: 32]                = count_q;
    end

endmodule

// File: doc/rand_stream_mst_mc.md
Name: rand_stream_mst_mc

Overview:
- Synthesizable, multi-channel randomizing ready/valid stream master for testbenches and on-FPGA traffic generation.
- Drives NumChannels independent streams with per-channel LFSR-randomized inter-transfer gaps.
- Data is either pseudo-random or a per-channel incrementing counter.
- Supports enable gating and a transaction limit with a done flag; output sequences are deterministic and reproducible from Seed.

Parameters:
- NumChannels, 4, number of independent stream channels (>=1).
- DataWidth, 32, payload width per channel (1..64).
- MinWaitCycles, 0, minimum idle cycles between transfers.
- MaxWaitCycles, 7, maximum idle cycles; must be >= MinWaitCycles (elaboration error otherwise).
- Seed, 32'hACE12345, base LFSR seed.
- NumTransactions, 0, handshakes per channel before done; 0 = unlimited.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- enable_i  in  NumChannels  per-channel start/continue request.
- mode_i  in  1  data mode, sampled at each data update: 0 = random, 1 = counter.
- data_o  out  NumChannels x DataWidth  per-channel payload.
- valid_o  out  NumChannels  per-channel valid.
- ready_i  in  NumChannels  per-channel ready.
- count_o  out  NumChannels x 32  completed handshakes per channel; saturates at 2^32-1.
- done_o  out  NumChannels  channel reached NumTransactions.

Behaviour:
- Reset (async assert): data_o=0, valid_o=0, count_o=0, done_o=0, all FSMs to IDLE.
  - Wait LFSR of channel c = Seed ^ (c*32'h9E3779B9); data LFSR = bitwise inverse of that value. An all-zero value is replaced by 32'h1.
  - Deassertion is used directly; reset synchronisation is outside this block.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, mask 32'h80200003. Advances exactly once per draw.
- Wait draw: advance the wait LFSR, then W = MinWaitCycles + (lfsr % (MaxWaitCycles-MinWaitCycles+1)).
- Data update:
  - Random mode: advance the data LFSR; data = {lfsr, lfsr} truncated to DataWidth LSBs.
  - Counter mode: data = per-channel counter (reset 0), incremented after each handshake, wrapping mod 2^DataWidth.
- Handshake: rising edge with valid_o[c] & ready_i[c].
- Per-channel FSM states IDLE, WAIT, VALID, DONE. Transitions:
  - IDLE: on an edge with enable_i[c]=1, draw W and perform a data update. If W==0, go to VALID (valid high after this edge). Otherwise go to WAIT with cnt=W.
  - WAIT: valid low; cnt decrements each edge. At the edge where cnt==1, go to VALID. Valid is therefore low for exactly W cycles.
  - VALID: valid_o=1. data_o is stable until handshake; neither valid nor data is ever retracted, regardless of enable_i or mode_i. On handshake:
    - Increment count_o.
    - If count reaches NumTransactions (!=0): go to DONE.
    - Else if enable_i[c]=0: go to IDLE.
    - Else draw W and perform a data update. If W==0, stay in VALID with new data next cycle (back-to-back). Otherwise go to WAIT with cnt=W.
  - DONE: valid_o=0, done_o=1, data_o holds; exits only via reset.
- Enable:
  - Deassertion in WAIT: abort to IDLE at the next edge; valid stays low; the drawn W is discarded.
  - Deassertion in VALID: takes effect only after the handshake.
- Channels are fully independent. No combinational path from ready_i to valid_o or data_o.
- Reset mid-transfer: outputs clear immediately; after release the sequence replays identically to the first run.

Test Plan:
- Min=Max=0, mode=1, ready=all 1, enable=all 1 at cycle 0 -> every channel has valid high from cycle 1; data 0,1,2,3,... one per cycle; count_o increments every cycle.
- Min=Max=3, mode=1, ready=1 -> valid low exactly 3 cycles before each 1-cycle valid pulse; data 0,1,2,...; count_o=4 after the 4th pulse.
- Channel 0 valid with ready_i[0] low for 5 cycles, mode toggled meanwhile -> data_o[0] and valid_o[0] unchanged for all 5 cycles; count_o[0] unchanged; updates only after the handshake. Other channels unaffected.
- NumTransactions=4, Min=Max=0, ready=1 -> exactly 4 handshakes per channel; done_o rises with valid low at the cycle after the 4th; stays low despite enable=1.
- enable_i[1] dropped while valid_o[1]=1 and ready low -> valid held until ready; after the handshake the channel goes IDLE with valid low. Re-enabling restarts the wait draw.
- Mode 0, Min=0, Max=7: run 100 transfers, assert rst_ni low mid-transfer, rerun -> outputs 0 during reset; post-reset data and gap sequence bit-identical to the first run; all gaps within 0..7.
